// File: rtl/memory_block_port_pkg.sv
// Shared constants for the memory block initiator port.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package memory_block_port_pkg;

  // Data word width of the basic memory block.
  localparam int WORD_W = 16;

  // A new request is allowed only if every outstanding read (buffered or
  // still on the memory pins) is guaranteed a buffer slot.
  function automatic logic has_credit(input int unsigned count,
                                      input int unsigned inflight,
                                      input int unsigned depth);
    return (count + inflight) < depth;
  endfunction

endpackage

// File: rtl/memory_response_fifo.sv
// Response buffer: DEPTH x WORD_W circular FIFO, head visible combinationally.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
//
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   push, push_data       store push_data at the tail on the clock edge
//   pop                   drop the head entry on the clock edge
//   head_data             current head entry (meaningless when count == 0)
//   count                 number of stored entries, 0..DEPTH
module memory_response_fifo
  import memory_block_port_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WORD_W-1:0]            push_data,
  input  logic                         pop,
  output logic [WORD_W-1:0]            head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] buf_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; count guards every read of it.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = buf_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/memory_block_port.sv
// Initiator port: valid/ready read/write requests to 1-cycle synchronous-read memory pins.
// Latency: read fire -> resp_valid next cycle when the buffer is empty; writes give no response.
// Backpressure: req_ready from credits (buffered + in-flight < RESP_DEPTH); resp held while !resp_ready.
//
// Ports:
//   clock, reset_n                      clock and asynchronous active-low reset
//   req_valid/req_ready                 request handshake
//   req_write, req_address, req_data    request payload (req_data ignored for reads)
//   resp_valid/resp_ready, resp_data    read response stream, in issue order
//   mem_write_enable, mem_read_address,
//   mem_write_address, mem_data_in      driven to the memory block
//   mem_data_out                        memory read data, valid the cycle after the address
module memory_block_port
  import memory_block_port_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WIDTH-1:0]  req_address,
  input  logic [WORD_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_data,
  output logic              mem_write_enable,
  output logic [WIDTH-1:0]  mem_read_address,
  output logic [WIDTH-1:0]  mem_write_address,
  output logic [WORD_W-1:0] mem_data_in,
  input  logic [WORD_W-1:0] mem_data_out
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic              inflight_q, inflight_d;
  logic [CW-1:0]     resp_count;
  logic [WORD_W-1:0] head_data;
  logic              buf_empty;
  logic              fire;
  logic              push;
  logic              pop;

  always_comb begin
    buf_empty = (resp_count == '0);

    // reset_n gating keeps req_ready (and thus any write strobe) low for
    // the whole time reset is asserted, not just after the first edge.
    req_ready = reset_n &
                has_credit(32'(resp_count), 32'(inflight_q), RESP_DEPTH);
    fire      = req_valid & req_ready;

    mem_write_enable  = fire & req_write;
    mem_read_address  = req_address;
    mem_write_address = req_address;
    mem_data_in       = req_data;

    inflight_d = fire & ~req_write;

    // Older buffered words must leave first; the memory word only bypasses
    // the buffer when nothing is queued ahead of it.
    resp_valid = inflight_q | ~buf_empty;
    resp_data  = buf_empty ? mem_data_out : head_data;

    pop  = ~buf_empty & resp_ready;
    // The returning word is stored unless it was consumed via the bypass.
    push = inflight_q & ~(buf_empty & resp_ready);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  memory_response_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (mem_data_out),
    .pop       (pop),
    .head_data (head_data),
    .count     (resp_count)
  );

endmodule

// File: tb/tb_memory_block_port.sv
module tb_memory_block_port;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_address;
  logic [15:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        mem_write_enable;
  logic [7:0]  mem_read_address;
  logic [7:0]  mem_write_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;

  always #5 clock = ~clock;

  memory_block_port #(.WIDTH(8), .RESP_DEPTH(2)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_address       (req_address),
    .req_data          (req_data),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_data         (resp_data),
    .mem_write_enable  (mem_write_enable),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_data_in       (mem_data_in),
    .mem_data_out      (mem_data_out)
  );

  // Basic memory block: synchronous write, synchronous 1-cycle read.
  logic [15:0] mem_array [256];
  always @(posedge clock) begin
    if (mem_write_enable) mem_array[mem_write_address] <= mem_data_in;
    mem_data_out <= mem_array[mem_read_address];
  end

  // Reference model: architectural memory contents plus the list of read
  // results still owed to the consumer, in issue order.
  logic [15:0] ref_mem [256];
  logic [15:0] exp_q [$];

  int   errors = 0;
  int   checks = 0;
  logic fired;
  int   n_rd = 0;
  int   n_resp = 0;
  int   fires;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model, then advance the model by this cycle's handshakes.
  task automatic step(input logic v, input logic w, input logic [7:0] a,
                      input logic [15:0] d, input logic rr);
    @(negedge clock);
    req_valid   = v;
    req_write   = w;
    req_address = a;
    req_data    = d;
    resp_ready  = rr;
    #1;
    chk_bit("req_ready", req_ready, exp_q.size() < 2);
    chk_bit("resp_valid", resp_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) chk_word("resp_data", resp_data, exp_q[0]);
    chk_word("mem_addr", {mem_read_address, mem_write_address}, {a, a});
    fired = v && (exp_q.size() < 2);
    chk_bit("mem_we", mem_write_enable, fired && w);
    if (exp_q.size() > 0 && rr) begin
      void'(exp_q.pop_front());
      n_resp++;
    end
    if (fired) begin
      if (w) ref_mem[a] = d;
      else begin
        exp_q.push_back(ref_mem[a]);
        n_rd++;
      end
    end
  endtask

  // Hold a request until it fires, with a bounded wait.
  task automatic do_op(input logic w, input logic [7:0] a, input logic [15:0] d,
                       input logic rr);
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) step(1'b1, w, a, d, rr);
    if (!fired) begin
      checks++;
      errors++;
      $error("FAIL do_op_timeout observed=no_fire expected=fire addr=%h", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    chk_int("drained", exp_q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b1;
    req_address = 8'h00; req_data = 16'h0; resp_ready = 1'b1;
    #1;
    chk_bit("rst_req_ready", req_ready, 1'b0);
    chk_bit("rst_resp_valid", resp_valid, 1'b0);
    chk_bit("rst_mem_we", mem_write_enable, 1'b0);
    repeat (2) @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b1;

    // Preload the low addresses used by every later read.
    for (int i = 0; i < 16; i++) do_op(1'b1, 8'(i), 16'($urandom), 1'b1);

    // 1: write then read, response one cycle after fire.
    do_op(1'b1, 8'h10, 16'h1234, 1'b1);
    do_op(1'b0, 8'h10, 16'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    chk_word("t1_data", resp_data, 16'h1234);

    // 2: back-to-back reads at full rate.
    for (int i = 0; i < 4; i++) do_op(1'b1, 8'(i), 16'hA000 + 16'(i), 1'b1);
    fires = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'(i), 16'h0, 1'b1);
      if (fired) fires++;
    end
    chk_int("t2_fires", fires, 4);
    drain();

    // 3: stalled consumer, only two reads fit.
    fires = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, (fires == 0) ? 8'h00 : (fires == 1) ? 8'h01 : 8'h02, 16'h0, 1'b0);
      if (fired) fires++;
    end
    chk_int("t3_fires_stalled", fires, 2);
    do_op(1'b0, 8'h02, 16'h0, 1'b1);
    drain();
    chk_int("t3_all_returned", n_resp, n_rd);

    // 4: read-old, write, read-new on the same address.
    do_op(1'b1, 8'h20, 16'h5555, 1'b1);
    do_op(1'b0, 8'h20, 16'h0, 1'b1);
    do_op(1'b1, 8'h20, 16'hBEEF, 1'b1);
    do_op(1'b0, 8'h20, 16'h0, 1'b1);
    drain();

    // 5: reset with one word buffered and one read in flight.
    do_op(1'b0, 8'h03, 16'h0, 1'b0);
    do_op(1'b0, 8'h20, 16'h0, 1'b0);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_address = 8'h20; req_data = 16'hDEAD;
    reset_n = 1'b0;
    #1;
    chk_bit("t5_resp_valid", resp_valid, 1'b0);
    chk_bit("t5_req_ready", req_ready, 1'b0);
    chk_bit("t5_mem_we", mem_write_enable, 1'b0);
    exp_q.delete();
    n_resp = n_rd;
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    do_op(1'b0, 8'h20, 16'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    chk_word("t5_mem_kept", resp_data, 16'hBEEF);
    drain();

    // 6: random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
           8'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 99) < 70);
    end
    drain();
    chk_int("t6_no_drop_dup", n_resp, n_rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
